// File: rtl/im_vga_scan_if.sv
// ---------------------------------------------------------------------------
// im_vga_scan_if -- signal bundle between the VGA scan engine, its image
// memory and the display pins.
//
//   en           scan enable; 0 holds the scan engine idle
//   pixel_x/y    10-bit column/row address presented to the image memory
//   rgb_in       12-bit read data {R,G,B}, valid 1 clk after the address
//   vga_r/g/b    4-bit display colour
//   vga_hs/vs    display syncs, active-low
//   video_on     high while the displayed pixel is in the active area
//   frame_start  one-clk pulse at the start of each frame
//
// The scan engine uses the master modport. The memory/display side uses the
// slave modport.
// ---------------------------------------------------------------------------
interface im_vga_scan_if;
    logic        en;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [11:0] rgb_in;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        video_on;
    logic        frame_start;

    modport master (
        input  en, rgb_in,
        output pixel_x, pixel_y, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, video_on, frame_start
    );

    modport slave (
        output en, rgb_in,
        input  pixel_x, pixel_y, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, video_on, frame_start
    );
endinterface

// File: rtl/im_vga_scan.sv
// ---------------------------------------------------------------------------
// im_vga_scan -- VGA raster scan generator that fetches pixels from an
// external image memory.
//
// A clock divider produces one pix_tick every CLK_DIV clks. On each tick the
// h/v counters advance. The memory address (pixel_x/pixel_y) for the new
// position is registered, and the output stage captures the colour that
// memory returned for the position just left. Because of this, every
// display output lags the address by exactly one pixel period, and sync
// and colour stay aligned with each other.
//
// Ports:
//   clk   system clock (single domain)
//   rst   asynchronous, active-high reset
//   bus   im_vga_scan_if.master: en, rgb_in in; pixel_x/y, colour,
//         syncs, video_on, frame_start out
// ---------------------------------------------------------------------------
module im_vga_scan #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic clk,
    input  logic rst,
    im_vga_scan_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;
    logic             pix_tick;
    logic             running;   // set after the first enabled clk; drives the first frame_start
    logic             cur_active;
    logic             nxt_active;

    always_comb begin
        pix_tick = bus.en && (div_cnt == DIV_LAST);

        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
        end

        cur_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        nxt_active = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    end

    // NOTE: every register is assigned with <= so all of them sample the
    // pre-edge values. The output stage therefore sees the position being
    // left while the counters move on in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every flop, including the output stage, has a reset value.
        // This lets the display pins come up idle before the first clock.
        if (rst) begin
            div_cnt         <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            running         <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.video_on    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else if (!bus.en) begin
            div_cnt         <= '0;
            h_cnt           <= '0;
            v_cnt           <= '0;
            running         <= 1'b0;
            bus.pixel_x     <= '0;
            bus.pixel_y     <= '0;
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
            bus.video_on    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            // The idle state already sits at (0,0). The first enabled clk
            // therefore marks the start of the first frame. A tick cannot
            // land in that clk, because div_cnt is 0 and CLK_DIV >= 2.
            running         <= 1'b1;
            bus.frame_start <= !running;

            if (pix_tick) begin
                div_cnt <= '0;
                h_cnt   <= h_nxt;
                v_cnt   <= v_nxt;
                if ((h_nxt == '0) && (v_nxt == '0))
                    bus.frame_start <= 1'b1;

                // The address for the position being entered is 0 in blanking.
                bus.pixel_x <= nxt_active ? h_nxt : '0;
                bus.pixel_y <= nxt_active ? v_nxt : '0;

                // rgb_in has been stable for CLK_DIV-1 clks for the position being left.
                bus.video_on <= cur_active;
                bus.vga_r    <= cur_active ? bus.rgb_in[11:8] : 4'd0;
                bus.vga_g    <= cur_active ? bus.rgb_in[7:4]  : 4'd0;
                bus.vga_b    <= cur_active ? bus.rgb_in[3:0]  : 4'd0;
                bus.vga_hs   <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
                bus.vga_vs   <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/im_vga_scan.md
IM_VGA_SCAN -- requirements
Module: im_vga_scan

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per pixel (100 MHz clk -> 25 MHz pixel rate); legal values 2..16.
REQ-002 Parameter H_ACTIVE, default 640; H_FP, default 16; H_SYNC, default 96; H_BP, default 48: horizontal timing in pixels.
REQ-003 Parameter V_ACTIVE, default 480; V_FP, default 10; V_SYNC, default 2; V_BP, default 33: vertical timing in lines.
REQ-004 Port clk  input  1  system clock; single clock domain.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port en  input  1  scan enable; 0 holds the block idle.
REQ-007 Port pixel_x  output  10  column address to image memory.
REQ-008 Port pixel_y  output  10  row address to image memory.
REQ-009 Port rgb_in  input  12  image memory read data {R[11:8],G[7:4],B[3:0]}; valid 1 clk after pixel_x/pixel_y change.
REQ-010 Port vga_r, vga_g, vga_b  output  4 each  display colour.
REQ-011 Port vga_hs, vga_vs  output  1 each  display syncs, active-low.
REQ-012 Port video_on  output  1  high while the displayed pixel is in the active area.
REQ-013 Port frame_start  output  1  one-clk pulse at the start of each frame.

Function
REQ-014 Divider div_cnt counts 0..CLK_DIV-1 and wraps; pix_tick is asserted for the one clk in which div_cnt == CLK_DIV-1.
REQ-015 On pix_tick, h_cnt increments; at H_TOTAL-1 = H_ACTIVE+H_FP+H_SYNC+H_BP-1 (799) it wraps to 0 and v_cnt increments.
REQ-016 v_cnt wraps from V_TOTAL-1 (524) to 0 on the same pix_tick on which h_cnt wraps.
REQ-017 pixel_x and pixel_y are registered; they equal h_cnt and v_cnt when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE, and are 0 otherwise.
REQ-018 pixel_x and pixel_y change only in the clk after pix_tick, so rgb_in is stable for at least CLK_DIV-1 clks before the next pix_tick.
REQ-019 Output stage, updated on pix_tick only: vga_r/g/b are rgb_in when the previous pixel was active, else 0; video_on, vga_hs and vga_vs reflect the previous pixel.
REQ-020 Together, REQ-019 gives display outputs a fixed one-pixel-period lag behind pixel_x/pixel_y; sync and colour stay mutually aligned.
REQ-021 vga_hs is 0 for pixels with H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751), else 1.
REQ-022 vga_vs is 0 for lines with V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491), else 1.
REQ-023 frame_start pulses high for exactly one clk, in the clk after the pix_tick that moves the counters to (0,0); this includes the first frame after en rises.
REQ-024 Counter and output widths: h_cnt and v_cnt are 10 bits; no count reaches 1024 with the default or any legal parameters.
REQ-025 en = 0: div_cnt, h_cnt and v_cnt are forced to 0; pixel_x = pixel_y = 0; colours = 0; vga_hs = vga_vs = 1; video_on = 0; no frame_start.
REQ-026 en deasserted mid-frame: the next clk applies the idle values of REQ-025; on re-enable, the scan restarts at (0,0) with a frame_start pulse.
REQ-027 en rising: the first pix_tick occurs CLK_DIV clks later.

Reset
REQ-028 rst = 1 immediately, without a clk edge, forces: div_cnt = h_cnt = v_cnt = 0; pixel_x = pixel_y = 0; vga_r = vga_g = vga_b = 0; vga_hs = vga_vs = 1; video_on = 0; frame_start = 0.
REQ-029 Reset asserted mid-frame aborts the scan; after deassertion with en = 1, operation matches REQ-027.

Verification
REQ-030 Release reset with en=1 and CLK_DIV=4 -> pixel_x steps 0,1,2,... every 4 clks; frame_start pulses once; first visible colour equals rgb_in returned for (0,0).
REQ-031 Count clks across one line -> vga_hs low for exactly 96*4 = 384 clks, starting 656*4 clks after line start; line period = 3200 clks.
REQ-032 Run a full frame -> vga_vs low for 2 lines (6400 clks); frame period = 420000*4 = 1680000 clks; exactly one frame_start per frame.
REQ-033 Memory model returns 'hE12 for (0,0) and 'hFFF elsewhere with 1-clk latency -> display shows r/g/b = E/1/2 for the first pixel, F/F/F for the rest of the active area, and 0 in blanking.
REQ-034 Blanking check: h_cnt = 700 -> pixel_x = 0, video_on = 0 and colour = 0 one pixel later, even with rgb_in = 'hFFF.
REQ-035 Drop en at (320,240), then assert rst mid-line -> idle values appear within 1 clk (immediately for rst); re-enable -> restart at (0,0) with frame_start and first pix_tick after 4 clks.
